// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: execute-stage bypass select encodings,
// used by the hazard unit and by the execute-stage operand muxes.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_if.sv
// Decode/execute hazard signals exchanged between the pipeline datapath
// (master) and the hazard unit (slave).
interface hazard_unit_if #(
    parameter int REGW = 5
) ();

    logic [REGW-1:0] rs_D;
    logic [REGW-1:0] rt_D;
    logic [REGW-1:0] writereg_E;
    logic            regwrite_E;
    logic            memtoreg_E;
    logic            branch_taken_E;
    logic [1:0]      forward_A;
    logic [1:0]      forward_B;
    logic            stall_F;
    logic            stall_D;
    logic            flush_D;
    logic            flush_E;

    modport master (
        output rs_D, rt_D, writereg_E, regwrite_E, memtoreg_E, branch_taken_E,
        input  forward_A, forward_B, stall_F, stall_D, flush_D, flush_E
    );

    modport slave (
        input  rs_D, rt_D, writereg_E, regwrite_E, memtoreg_E, branch_taken_E,
        output forward_A, forward_B, stall_F, stall_D, flush_D, flush_E
    );

endinterface : hazard_unit_if

// File: rtl/hazard_unit_fwd_sel.sv
// Bypass select for one execute-stage source operand; the MEM producer is
// younger than the WB producer, so it is checked first.
module fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] src_i,
    input  logic [REGW-1:0] writereg_m_i,
    input  logic            regwrite_m_i,
    input  logic            memtoreg_m_i,
    input  logic [REGW-1:0] writereg_w_i,
    input  logic            regwrite_w_i,
    output fwd_sel_e        sel_o
);

    logic mem_hit_s;
    logic wb_hit_s;

    // Register 0 is hard-wired, so it never takes a bypass; a load in MEM has no data yet
    always_comb begin
        mem_hit_s = regwrite_m_i && !memtoreg_m_i &&
                    (writereg_m_i != {REGW{1'b0}}) && (writereg_m_i == src_i);
        wb_hit_s  = regwrite_w_i &&
                    (writereg_w_i != {REGW{1'b0}}) && (writereg_w_i == src_i);
        sel_o     = FWD_RF;
        if (mem_hit_s) begin
            sel_o = FWD_MEM;
        end else if (wb_hit_s) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule : fwd_sel

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX sources and MEM/WB destinations to drive
// execute bypass selects, load-use stalls and taken-branch flushes.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_if.slave hz
);

    logic [REGW-1:0] rs_e_q, rs_e_d;
    logic [REGW-1:0] rt_e_q, rt_e_d;
    logic [REGW-1:0] writereg_m_q, writereg_m_d;
    logic            regwrite_m_q, regwrite_m_d;
    logic            memtoreg_m_q, memtoreg_m_d;
    logic [REGW-1:0] writereg_w_q, writereg_w_d;
    logic            regwrite_w_q, regwrite_w_d;

    logic            load_use_s;
    logic            stall_s;
    logic            flush_d_s;
    logic            flush_e_s;
    fwd_sel_e        fwd_a_s;
    fwd_sel_e        fwd_b_s;

    // Hazard decisions; a taken branch squashes the stalled instruction anyway
    always_comb begin
        load_use_s = hz.regwrite_E && hz.memtoreg_E &&
                     (hz.writereg_E != {REGW{1'b0}}) &&
                     ((hz.writereg_E == hz.rs_D) || (hz.writereg_E == hz.rt_D));
        stall_s    = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        if (reset) begin
            stall_s   = 1'b0;
            flush_d_s = 1'b0;
            flush_e_s = 1'b0;
        end else if (hz.branch_taken_E) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (load_use_s) begin
            stall_s   = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_s   = 1'b0;
        end
    end

    // Next-state of the tracked stage fields; MEM and WB always advance
    always_comb begin
        if (flush_e_s) begin
            rs_e_d = {REGW{1'b0}};
            rt_e_d = {REGW{1'b0}};
        end else begin
            rs_e_d = hz.rs_D;
            rt_e_d = hz.rt_D;
        end
        writereg_m_d = hz.writereg_E;
        regwrite_m_d = hz.regwrite_E;
        memtoreg_m_d = hz.memtoreg_E;
        writereg_w_d = writereg_m_q;
        regwrite_w_d = regwrite_m_q;
    end

    // Stage tracking registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_e_q       <= {REGW{1'b0}};
            rt_e_q       <= {REGW{1'b0}};
            writereg_m_q <= {REGW{1'b0}};
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            writereg_w_q <= {REGW{1'b0}};
            regwrite_w_q <= 1'b0;
        end else begin
            rs_e_q       <= rs_e_d;
            rt_e_q       <= rt_e_d;
            writereg_m_q <= writereg_m_d;
            regwrite_m_q <= regwrite_m_d;
            memtoreg_m_q <= memtoreg_m_d;
            writereg_w_q <= writereg_w_d;
            regwrite_w_q <= regwrite_w_d;
        end
    end

    fwd_sel #(.REGW(REGW)) u_fwd_a (
        .src_i        (rs_e_q),
        .writereg_m_i (writereg_m_q),
        .regwrite_m_i (regwrite_m_q),
        .memtoreg_m_i (memtoreg_m_q),
        .writereg_w_i (writereg_w_q),
        .regwrite_w_i (regwrite_w_q),
        .sel_o        (fwd_a_s)
    );

    fwd_sel #(.REGW(REGW)) u_fwd_b (
        .src_i        (rt_e_q),
        .writereg_m_i (writereg_m_q),
        .regwrite_m_i (regwrite_m_q),
        .memtoreg_m_i (memtoreg_m_q),
        .writereg_w_i (writereg_w_q),
        .regwrite_w_i (regwrite_w_q),
        .sel_o        (fwd_b_s)
    );

    assign hz.forward_A = fwd_a_s;
    assign hz.forward_B = fwd_b_s;
    assign hz.stall_F   = stall_s;
    assign hz.stall_D   = stall_s;
    assign hz.flush_D   = flush_d_s;
    assign hz.flush_E   = flush_e_s;

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random stimulus compared
// every cycle against a producer-history reference model.
module tb_hazard_unit;

    localparam int REGW = 5;

    typedef struct {
        logic [REGW-1:0] dst;
        bit              wr;
        bit              ld;
    } prod_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_if #(.REGW(REGW)) hz ();
    hazard_unit #(.REGW(REGW)) dut (.clk(clk), .reset(reset), .hz(hz));

    int vectors = 0;
    int errors  = 0;

    // Reference model: producers[0] is one instruction older than EX (MEM), [1] is two older (WB)
    prod_t           producers[2];
    logic [REGW-1:0] ex_src[2];
    logic [1:0]      last_fa, last_fb;
    logic            last_sf, last_sd, last_fd, last_fe;

    function automatic logic [1:0] model_fwd(input logic [REGW-1:0] s);
        for (int k = 0; k < 2; k++) begin
            if (producers[k].wr && producers[k].dst != 0 && producers[k].dst == s) begin
                if (k == 1) return 2'b01;
                if (!producers[k].ld) return 2'b10;
            end
        end
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) producers[k] = '{dst: '0, wr: 1'b0, ld: 1'b0};
        ex_src[0] = '0;
        ex_src[1] = '0;
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive D/E inputs, compare against the model, advance the model
    task automatic apply(input logic [REGW-1:0] rs, input logic [REGW-1:0] rt,
                         input logic [REGW-1:0] we, input logic rw, input logic mt,
                         input logic br);
        logic lu, e_stall, e_fd, e_fe;
        hz.rs_D = rs; hz.rt_D = rt; hz.writereg_E = we;
        hz.regwrite_E = rw; hz.memtoreg_E = mt; hz.branch_taken_E = br;
        #1;
        if (reset) model_clear();
        lu      = rw && mt && we != 0 && (we == rs || we == rt);
        e_stall = !reset && !br && lu;
        e_fd    = !reset && br;
        e_fe    = !reset && (br || lu);
        chk("forward_A", hz.forward_A, model_fwd(ex_src[0]));
        chk("forward_B", hz.forward_B, model_fwd(ex_src[1]));
        chk("stall_F", {1'b0, hz.stall_F}, {1'b0, e_stall});
        chk("stall_D", {1'b0, hz.stall_D}, {1'b0, e_stall});
        chk("flush_D", {1'b0, hz.flush_D}, {1'b0, e_fd});
        chk("flush_E", {1'b0, hz.flush_E}, {1'b0, e_fe});
        last_fa = hz.forward_A; last_fb = hz.forward_B;
        last_sf = hz.stall_F;   last_sd = hz.stall_D;
        last_fd = hz.flush_D;   last_fe = hz.flush_E;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            producers[1] = producers[0];
            producers[0] = '{dst: we, wr: rw, ld: mt};
            ex_src[0]    = e_fe ? '0 : rs;
            ex_src[1]    = e_fe ? '0 : rt;
        end
        @(negedge clk);
    endtask

    // Outputs straight after the last clock edge, before new inputs arrive
    task automatic peek_fwd(input string nm, input logic [1:0] ea, input logic [1:0] eb);
        #1;
        chk({nm, "_A"}, hz.forward_A, ea);
        chk({nm, "_B"}, hz.forward_B, eb);
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        // Outputs quiet under reset even with hazardous-looking inputs
        apply(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        chk("rst_flushD", {1'b0, last_fd}, 2'b00);
        chk("rst_stallF", {1'b0, last_sf}, 2'b00);
        apply(5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        // add r3 in EX, consumer rs=3 in D -> MEM forward on A
        apply(5'd3, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        peek_fwd("t_mem", 2'b10, 2'b00);

        // producer r3 two ahead -> WB forward on B
        apply(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        apply(5'd2, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        peek_fwd("t_wb", 2'b00, 2'b01);
        // r3 in both MEM and WB -> MEM wins
        apply(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        peek_fwd("t_both", 2'b00, 2'b10);

        // lw r5 with rs_D=5: one-cycle stall, then WB forward
        apply(5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0);
        chk("lu_stallF", {1'b0, last_sf}, 2'b01);
        chk("lu_stallD", {1'b0, last_sd}, 2'b01);
        chk("lu_flushE", {1'b0, last_fe}, 2'b01);
        apply(5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_release", {1'b0, last_sf}, 2'b00);
        peek_fwd("lu_wb", 2'b01, 2'b00);

        // writes to r0 never forward
        apply(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        apply(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        peek_fwd("t_r0", 2'b00, 2'b00);

        // load-use and taken branch together: flush wins
        apply(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        chk("br_flushD", {1'b0, last_fd}, 2'b01);
        chk("br_flushE", {1'b0, last_fe}, 2'b01);
        chk("br_stallF", {1'b0, last_sf}, 2'b00);
        chk("br_stallD", {1'b0, last_sd}, 2'b00);

        // mid-stream reset with MEM/WB matches pending
        apply(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        apply(5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
        peek_fwd("pre_rst", 2'b10, 2'b10);
        reset = 1'b1;
        peek_fwd("in_rst", 2'b00, 2'b00);
        apply(5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        apply(5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        peek_fwd("post_rst", 2'b00, 2'b00);

        // Random traffic over a small register range to provoke collisions
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) reset = 1'b1;
            else                            reset = 1'b0;
            apply(REGW'($urandom_range(0, 7)), REGW'($urandom_range(0, 7)),
                  REGW'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_hazard_unit

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REGW, default 5, register-index width.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rs_D, rt_D  in  REGW  source registers of the instruction in decode.
REQ-005 SHALL have ports writereg_E  in  REGW, regwrite_E  in  1, memtoreg_E  in  1  destination info of the instruction in execute.
REQ-006 SHALL have port branch_taken_E  in  1  taken branch/jump resolved in execute.
REQ-007 SHALL have ports forward_A, forward_B  out  2  execute bypass selects: 00 register file, 01 WB result, 10 MEM ALU result; 11 never driven.
REQ-008 SHALL have ports stall_F, stall_D  out  1  hold PC and IF/ID register.
REQ-009 SHALL have ports flush_D, flush_E  out  1  bubble the IF/ID and ID/EX registers.

Function
REQ-010 SHALL track rs_E and rt_E (sources of the EX instruction) as registers loaded from rs_D/rt_D each cycle, or loaded with 0 when flush_E is high.
REQ-011 SHALL track MEM-stage state (writereg_M, regwrite_M, memtoreg_M) loaded from the *_E inputs every cycle, never stalled.
REQ-012 SHALL track WB-stage state (writereg_W, regwrite_W) loaded from the MEM-stage state every cycle.
REQ-013 SHALL compute forward_A combinationally: 10 if regwrite_M, !memtoreg_M, writereg_M!=0 and writereg_M==rs_E; else 01 if regwrite_W, writereg_W!=0 and writereg_W==rs_E; else 00.
REQ-014 SHALL compute forward_B with the same rule using rt_E.
REQ-015 SHALL give MEM priority over WB when both match (youngest producer wins).
REQ-016 SHALL never forward for register 0, regardless of regwrite.
REQ-017 SHALL detect load-use when regwrite_E, memtoreg_E, writereg_E!=0 and writereg_E equals rs_D or rt_D; then assert stall_F, stall_D and flush_E in that same cycle.
REQ-018 SHALL limit the load-use stall to exactly one cycle; the load then sits in MEM and the dependent instruction enters EX, and the dependency resolves via WB forward (01) once the load reaches WB.
REQ-019 SHALL, on branch_taken_E, assert flush_D and flush_E and deassert stall_F/stall_D, overriding any simultaneous load-use condition.
REQ-020 SHALL drive all outputs combinationally from inputs and internal state; internal tracking latency is one cycle per stage.

Reset
REQ-021 SHALL on reset clear rs_E, rt_E, writereg_M, writereg_W to 0 and regwrite_M, memtoreg_M, regwrite_W to 0.
REQ-022 SHALL drive forward_A=forward_B=00 and all stall/flush outputs low while reset is high, independent of the data inputs.
REQ-023 SHALL, after a mid-operation reset, perform no forwarding until new producers propagate (no stale matches).

Structure
REQ-024 SHALL take the forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) from a shared pipeline package, also used by the execute-stage bypass muxes.
REQ-025 SHALL be one module plus one sub-module, fwd_sel, instantiated twice (A and B) to implement REQ-013/014.

Verification
REQ-026 SHALL test: add r3 in EX (writereg_E=3, regwrite_E=1); next cycle rs_E=3 -> forward_A=10.
REQ-027 SHALL test: producer r3 two instructions ahead, consumer rt_E=3 -> forward_B=01; producers of r3 in both MEM and WB -> forward_B=10.
REQ-028 SHALL test: lw r5 in EX (memtoreg_E=1), rs_D=5 -> stall_F=stall_D=flush_E=1 for one cycle; two cycles later forward_A=01.
REQ-029 SHALL test: writereg=0 with regwrite=1 in MEM and WB, rs_E=rt_E=0 -> forward_A=forward_B=00.
REQ-030 SHALL test: load-use and branch_taken_E high in the same cycle -> flush_D=flush_E=1, stall_F=stall_D=0.
REQ-031 SHALL test: reset asserted mid-stream with MEM/WB matches pending -> all outputs 00/0 immediately; after release, no forwarding until a new producer arrives.
